// File: rtl/rc4_stream_xor.sv
// rc4_stream_xor: keystream FIFO, optional RC4-drop[N] discard, and the
// plaintext/keystream XOR stage with a registered ciphertext output.
// One framed message is processed per start pulse.
module rc4_stream_xor #(
   parameter int FIFO_DEPTH = 16,
   parameter int DROP_N     = 0
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic                          ks_init_done,
   output logic                          ks_en,
   input  logic                          ks_valid,
   input  logic [7:0]                    ks_data,
   input  logic                          pt_valid,
   output logic                          pt_ready,
   input  logic [7:0]                    pt_data,
   input  logic                          pt_last,
   output logic                          ct_valid,
   input  logic                          ct_ready,
   output logic [7:0]                    ct_data,
   output logic                          ct_last,
   output logic                          busy,
   output logic                          ks_ovf,
   output logic [$clog2(FIFO_DEPTH):0]   ks_level
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int LW = PW + 1;
   localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);
   localparam logic [9:0]    DROP_LAST  = 10'(DROP_N - 1);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_KS,
      DROP,
      RUN,
      DRAIN
   } state_t;

   state_t          state_q, state_d;
   logic [7:0]      mem_q [FIFO_DEPTH];
   logic [7:0]      mem_d [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]   level_q, level_d;
   logic [9:0]      drop_cnt_q, drop_cnt_d;
   logic            ks_en_q, ks_en_d;
   logic            ks_ovf_q, ks_ovf_d;
   logic            ct_valid_q, ct_valid_d;
   logic [7:0]      ct_data_q, ct_data_d;
   logic            ct_last_q, ct_last_d;

   logic            pt_ready_int;
   logic            xfer;
   logic            push_req;
   logic            push;
   logic            fifo_full;
   logic            start_idle;
   logic            ct_out;
   logic            flush;

   // Handshake qualifiers shared by the FSM, FIFO and output register.
   always_comb begin
      start_idle   = (state_q == IDLE) && start;
      ct_out       = ct_valid_q && ct_ready;
      fifo_full    = (level_q == FULL_LEVEL);
      pt_ready_int = (state_q == RUN) && (level_q != '0) && (!ct_valid_q || ct_ready);
      xfer         = pt_valid && pt_ready_int;
      push_req     = (state_q == RUN) && ks_valid;
      push         = push_req && (!fifo_full || xfer);
      flush        = start_idle || ((state_q == DRAIN) && ct_out);
   end

   // Session state machine: next-state decision.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = WAIT_KS;
         WAIT_KS: if (ks_init_done) state_d = (DROP_N > 0) ? DROP : RUN;
         DROP:    if (ks_valid && (drop_cnt_q == DROP_LAST)) state_d = RUN;
         RUN:     if (xfer && pt_last) state_d = DRAIN;
         DRAIN:   if (ct_out) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Drop counter, generator enable and sticky overflow flag.
   always_comb begin
      drop_cnt_d = drop_cnt_q;
      ks_ovf_d   = ks_ovf_q;
      ks_en_d    = (state_d == DROP) || (state_d == RUN);
      if (start_idle) begin
         drop_cnt_d = '0;
         ks_ovf_d   = 1'b0;
      end else begin
         if ((state_q == DROP) && ks_valid) begin
            drop_cnt_d = (drop_cnt_q == DROP_LAST) ? '0 : drop_cnt_q + 10'd1;
         end
         if (push_req && fifo_full && !xfer) begin
            ks_ovf_d = 1'b1;
         end
      end
   end

   // Keystream FIFO: tail write on push, head advance on transfer, flush on session edges.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = ks_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
         end
         if (xfer) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         case ({push, xfer})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
         endcase
      end
   end

   // Ciphertext output register: load on transfer, retire on downstream accept.
   always_comb begin
      ct_valid_d = ct_valid_q;
      ct_data_d  = ct_data_q;
      ct_last_d  = ct_last_q;
      if (xfer) begin
         ct_valid_d = 1'b1;
         ct_data_d  = pt_data ^ mem_q[rd_ptr_q];
         ct_last_d  = pt_last;
      end else if (ct_out) begin
         ct_valid_d = 1'b0;
      end
   end

   // State register for every flop in the block.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         drop_cnt_q <= '0;
         ks_en_q    <= 1'b0;
         ks_ovf_q   <= 1'b0;
         ct_valid_q <= 1'b0;
         ct_data_q  <= '0;
         ct_last_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         mem_q      <= mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         drop_cnt_q <= drop_cnt_d;
         ks_en_q    <= ks_en_d;
         ks_ovf_q   <= ks_ovf_d;
         ct_valid_q <= ct_valid_d;
         ct_data_q  <= ct_data_d;
         ct_last_q  <= ct_last_d;
      end
   end

   assign ks_en    = ks_en_q;
   assign pt_ready = pt_ready_int;
   assign ct_valid = ct_valid_q;
   assign ct_data  = ct_data_q;
   assign ct_last  = ct_last_q;
   assign busy     = (state_q != IDLE);
   assign ks_ovf   = ks_ovf_q;
   assign ks_level = level_q;

endmodule
